// File: rtl/redirect_merge_pkg.sv
// Shared types and widths for the redirect merge stage.
// Optional perf counters are enabled with `define REDIRECT_MERGE_PERF_EN.
package redirect_merge_pkg;

   localparam int unsigned FTQ_IDX_W = 6;
   localparam int unsigned FTQ_PTR_W = FTQ_IDX_W + 1;
   localparam int unsigned OFFSET_W  = 4;
   localparam int unsigned PC_W      = 50;
   localparam int unsigned PERF_W    = 32;

   typedef struct packed {
      logic                 flag;
      logic [FTQ_IDX_W-1:0] idx;
   } ftq_ptr_t;

   typedef enum logic {
      SRC_BK  = 1'b0,
      SRC_IFU = 1'b1
   } redir_src_e;

   typedef struct packed {
      redir_src_e          src;
      ftq_ptr_t            ptr;
      logic [OFFSET_W-1:0] offset;
      logic [PC_W-1:0]     target;
      logic                level;
      logic                taken;
   } redirect_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   // Saturating add of a small event count onto a perf counter.
   function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] cnt,
                                                 input logic [1:0]        inc);
      logic [PERF_W:0] sum;
      sum = {1'b0, cnt} + (PERF_W+1)'(inc);
      return sum[PERF_W] ? {PERF_W{1'b1}} : sum[PERF_W-1:0];
   endfunction

endpackage

// File: rtl/redirect_age_cmp.sv
// Combinational age comparison of two {ptr, offset} redirect positions.
module redirect_age_cmp
   import redirect_merge_pkg::*;
(
   input  ftq_ptr_t            a_ptr,
   input  logic [OFFSET_W-1:0] a_offset,
   input  ftq_ptr_t            b_ptr,
   input  logic [OFFSET_W-1:0] b_offset,
   output logic                older,
   output logic                equal
);

   logic ptr_eq;

   // A older than B; differing flags mean B's pointer has wrapped past A.
   always_comb begin
      older  = 1'b0;
      equal  = 1'b0;
      ptr_eq = (a_ptr == b_ptr);
      if (ptr_eq) begin
         older = (a_offset < b_offset);
         equal = (a_offset == b_offset);
      end else if (a_ptr.flag == b_ptr.flag) begin
         older = (a_ptr.idx < b_ptr.idx);
      end else begin
         older = (a_ptr.idx > b_ptr.idx);
      end
   end

endmodule

// File: rtl/redirect_merge_stage.sv
// Merges backend and IFU redirects into a 1-entry output register with
// age-based replacement while the consumer stalls.
// Optional perf counters: `define REDIRECT_MERGE_PERF_EN.
module redirect_merge_stage
   import redirect_merge_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 bk_valid,
   input  logic [FTQ_PTR_W-1:0] bk_ftq_ptr,
   input  logic [OFFSET_W-1:0]  bk_ftq_offset,
   input  logic [PC_W-1:0]      bk_target,
   input  logic                 bk_level,
   input  logic                 bk_taken,
   input  logic                 ifu_valid,
   input  logic [FTQ_PTR_W-1:0] ifu_ftq_ptr,
   input  logic [OFFSET_W-1:0]  ifu_ftq_offset,
   input  logic [PC_W-1:0]      ifu_target,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_src,
   output logic [FTQ_PTR_W-1:0] out_ftq_ptr,
   output logic [OFFSET_W-1:0]  out_ftq_offset,
   output logic [PC_W-1:0]      out_target,
   output logic                 out_level,
   output logic                 out_taken
`ifdef REDIRECT_MERGE_PERF_EN
   ,
   output logic [PERF_W-1:0]    perf_accept_cnt,
   output logic [PERF_W-1:0]    perf_drop_cnt
`endif
);

   state_e    state;
   redirect_t held;
   redirect_t cand;
   logic      cand_valid;
   logic      cand_older;
   logic      cand_equal;
   logic      replace;

   // Candidate select: backend always wins over IFU in the same cycle.
   always_comb begin
      cand       = '0;
      cand_valid = bk_valid | ifu_valid;
      if (bk_valid) begin
         cand.src    = SRC_BK;
         cand.ptr    = ftq_ptr_t'(bk_ftq_ptr);
         cand.offset = bk_ftq_offset;
         cand.target = bk_target;
         cand.level  = bk_level;
         cand.taken  = bk_taken;
      end else if (ifu_valid) begin
         cand.src    = SRC_IFU;
         cand.ptr    = ftq_ptr_t'(ifu_ftq_ptr);
         cand.offset = ifu_ftq_offset;
         cand.target = ifu_target;
         cand.level  = 1'b0;
         cand.taken  = 1'b1;
      end
   end

   redirect_age_cmp u_age_cmp (
      .a_ptr    (cand.ptr),
      .a_offset (cand.offset),
      .b_ptr    (held.ptr),
      .b_offset (held.offset),
      .older    (cand_older),
      .equal    (cand_equal)
   );

   // Stalled replacement: strictly older, or same position and backend over IFU.
   always_comb begin
      replace = cand_older |
                (cand_equal & (cand.src == SRC_BK) & (held.src == SRC_IFU));
   end

   // Two-state holding FSM with registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         held      <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cand_valid) begin
                  held      <= cand;
                  state     <= HOLD;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  if (cand_valid) begin
                     held <= cand;
                  end else begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                  end
               end else if (cand_valid && replace) begin
                  held <= cand;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_src        = held.src;
   assign out_ftq_ptr    = held.ptr;
   assign out_ftq_offset = held.offset;
   assign out_target     = held.target;
   assign out_level      = held.level;
   assign out_taken      = held.taken;

`ifdef REDIRECT_MERGE_PERF_EN
   logic       hold_drop;
   logic [1:0] drop_inc;
   logic [1:0] accept_inc;

   // Per-cycle event counts: same-cycle IFU loser plus a rejected stalled candidate.
   always_comb begin
      hold_drop  = (state == HOLD) & ~out_ready & cand_valid & ~replace;
      drop_inc   = 2'(bk_valid & ifu_valid) + 2'(hold_drop);
      accept_inc = 2'(out_valid & out_ready);
   end

   // Saturating perf counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_accept_cnt <= '0;
         perf_drop_cnt   <= '0;
      end else begin
         perf_accept_cnt <= sat_add(perf_accept_cnt, accept_inc);
         perf_drop_cnt   <= sat_add(perf_drop_cnt, drop_inc);
      end
   end
`endif

endmodule

// File: tb/tb_redirect_merge_stage.sv
// Bench for redirect_merge_stage: directed scenarios then random traffic,
// all checked against a queue-free positional reference model.
module tb_redirect_merge_stage;
   import redirect_merge_pkg::*;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 bk_valid = 1'b0;
   logic [FTQ_PTR_W-1:0] bk_ftq_ptr = '0;
   logic [OFFSET_W-1:0]  bk_ftq_offset = '0;
   logic [PC_W-1:0]      bk_target = '0;
   logic                 bk_level = 1'b0;
   logic                 bk_taken = 1'b0;
   logic                 ifu_valid = 1'b0;
   logic [FTQ_PTR_W-1:0] ifu_ftq_ptr = '0;
   logic [OFFSET_W-1:0]  ifu_ftq_offset = '0;
   logic [PC_W-1:0]      ifu_target = '0;
   logic                 out_ready = 1'b1;
   logic                 out_valid;
   logic                 out_src;
   logic [FTQ_PTR_W-1:0] out_ftq_ptr;
   logic [OFFSET_W-1:0]  out_ftq_offset;
   logic [PC_W-1:0]      out_target;
   logic                 out_level;
   logic                 out_taken;
`ifdef REDIRECT_MERGE_PERF_EN
   logic [31:0]          perf_accept_cnt;
   logic [31:0]          perf_drop_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: one held slot, positions as plain integers.
   bit             m_valid;
   bit             m_src;
   int             m_pos;   // flag*64 + idx
   int             m_off;
   logic [PC_W-1:0] m_target;
   bit             m_level;
   bit             m_taken;
   longint         m_acc;
   longint         m_drop;

   always #5 clock = ~clock;

   redirect_merge_stage dut (
      .clock          (clock),
      .reset          (reset),
      .bk_valid       (bk_valid),
      .bk_ftq_ptr     (bk_ftq_ptr),
      .bk_ftq_offset  (bk_ftq_offset),
      .bk_target      (bk_target),
      .bk_level       (bk_level),
      .bk_taken       (bk_taken),
      .ifu_valid      (ifu_valid),
      .ifu_ftq_ptr    (ifu_ftq_ptr),
      .ifu_ftq_offset (ifu_ftq_offset),
      .ifu_target     (ifu_target),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_src        (out_src),
      .out_ftq_ptr    (out_ftq_ptr),
      .out_ftq_offset (out_ftq_offset),
      .out_target     (out_target),
      .out_level      (out_level),
      .out_taken      (out_taken)
`ifdef REDIRECT_MERGE_PERF_EN
      ,
      .perf_accept_cnt(perf_accept_cnt),
      .perf_drop_cnt  (perf_drop_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A older than B: B lies 1..63 pointer steps ahead of A on the 128-step ring.
   function automatic bit is_older(input int apos, input int aoff, input int bpos, input int boff);
      int d;
      if (apos == bpos) return aoff < boff;
      d = (bpos - apos + 128) % 128;
      return (d >= 1) && (d <= 63);
   endfunction

   task automatic model_reset();
      m_valid = 0; m_src = 0; m_pos = 0; m_off = 0;
      m_target = '0; m_level = 0; m_taken = 0;
      m_acc = 0; m_drop = 0;
   endtask

   // Advance the model by one clock edge using the inputs present at the edge.
   task automatic model_edge();
      bit              cv, csrc, cl, ct;
      int              cpos, coff;
      logic [PC_W-1:0] ctgt;
      bit              take;
      cv = bk_valid || ifu_valid;
      if (bk_valid) begin
         csrc = 0; cpos = int'(bk_ftq_ptr); coff = int'(bk_ftq_offset);
         ctgt = bk_target; cl = bk_level; ct = bk_taken;
      end else begin
         csrc = 1; cpos = int'(ifu_ftq_ptr); coff = int'(ifu_ftq_offset);
         ctgt = ifu_target; cl = 0; ct = 1;
      end
      if (bk_valid && ifu_valid) m_drop++;
      if (m_valid && out_ready) m_acc++;
      take = 0;
      if (!m_valid || out_ready) begin
         take = cv;
         if (!cv) m_valid = 0;
      end else if (cv) begin
         take = is_older(cpos, coff, m_pos, m_off) ||
                (cpos == m_pos && coff == m_off && csrc == 0 && m_src == 1);
         if (!take) m_drop++;
      end
      if (take) begin
         m_valid = 1; m_src = csrc; m_pos = cpos; m_off = coff;
         m_target = ctgt; m_level = cl; m_taken = ct;
      end
   endtask

   task automatic check_model();
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
         chk("out_src", 64'(out_src), 64'(m_src));
         chk("out_ftq_ptr", 64'(out_ftq_ptr), 64'(m_pos));
         chk("out_ftq_offset", 64'(out_ftq_offset), 64'(m_off));
         chk("out_target", 64'(out_target), 64'(m_target));
         chk("out_level", 64'(out_level), 64'(m_level));
         chk("out_taken", 64'(out_taken), 64'(m_taken));
      end
`ifdef REDIRECT_MERGE_PERF_EN
      chk("perf_accept_cnt", 64'(perf_accept_cnt), 64'(m_acc));
      chk("perf_drop_cnt", 64'(perf_drop_cnt), 64'(m_drop));
`endif
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic set_bk(input int f, input int i, input int o, input logic [PC_W-1:0] t,
                         input bit l, input bit tk);
      bk_valid = 1; bk_ftq_ptr = {1'(f), 6'(i)}; bk_ftq_offset = 4'(o);
      bk_target = t; bk_level = l; bk_taken = tk;
   endtask

   task automatic set_ifu(input int f, input int i, input int o, input logic [PC_W-1:0] t);
      ifu_valid = 1; ifu_ftq_ptr = {1'(f), 6'(i)}; ifu_ftq_offset = 4'(o); ifu_target = t;
   endtask

   task automatic idle_inputs();
      bk_valid = 0; ifu_valid = 0;
   endtask

   task automatic drain();
      idle_inputs(); out_ready = 1;
      step(); step();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_target", 64'(out_target), 64'd0);
      chk("reset_ptr", 64'(out_ftq_ptr), 64'd0);
      chk("reset_taken", 64'(out_taken), 64'd0);
      reset = 0;

      // Single backend redirect, latency 1, then back to idle.
      set_bk(0, 5, 3, 50'h1000, 1, 0);
      step();
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_ptr", 64'(out_ftq_ptr), 64'h05);
      chk("single_target", 64'(out_target), 64'h1000);
      idle_inputs();
      step();
      chk("single_idle", 64'(out_valid), 64'd0);

      // Same-cycle collision: backend wins.
      set_bk(0, 7, 1, 50'h2000, 0, 1);
      set_ifu(0, 2, 0, 50'h3000);
      step();
      chk("collide_src", 64'(out_src), 64'd0);
      chk("collide_target", 64'(out_target), 64'h2000);
      drain();

      // Stalled: IFU held, older backend replaces, younger IFU dropped.
      out_ready = 0;
      set_ifu(0, 10, 0, 50'h4000);
      step();
      chk("hold_ifu_level", 64'(out_level), 64'd0);
      chk("hold_ifu_taken", 64'(out_taken), 64'd1);
      idle_inputs();
      set_bk(0, 4, 0, 50'h5000, 1, 1);
      step();
      chk("replace_valid", 64'(out_valid), 64'd1);
      chk("replace_ptr", 64'(out_ftq_ptr), 64'h04);
      idle_inputs();
      set_ifu(0, 12, 0, 50'h6000);
      step();
      chk("younger_drop_ptr", 64'(out_ftq_ptr), 64'h04);
      drain();

      // Wrap-around ordering.
      out_ready = 0;
      set_bk(0, 60, 0, 50'h7000, 0, 0);
      step();
      set_bk(1, 1, 0, 50'h7100, 0, 0);
      step();
      chk("wrap_keep_ptr", 64'(out_ftq_ptr), 64'h3C);
      drain();
      out_ready = 0;
      set_bk(1, 1, 0, 50'h7200, 0, 0);
      step();
      set_bk(0, 60, 0, 50'h7300, 0, 0);
      step();
      chk("wrap_replace_ptr", 64'(out_ftq_ptr), 64'h3C);
      chk("wrap_replace_target", 64'(out_target), 64'h7300);
      drain();

      // Equal position: backend displaces held IFU.
      out_ready = 0;
      idle_inputs();
      set_ifu(0, 20, 5, 50'h8000);
      step();
      idle_inputs();
      set_bk(0, 20, 5, 50'h8100, 1, 0);
      step();
      chk("equal_src", 64'(out_src), 64'd0);
      chk("equal_level", 64'(out_level), 64'd1);
      chk("equal_taken", 64'(out_taken), 64'd0);
      idle_inputs();
      step();

      // Asynchronous reset while holding.
      #2;
      reset = 1;
      set_bk(0, 9, 0, 50'h9000, 0, 0);
      #1;
      chk("async_reset_valid", 64'(out_valid), 64'd0);
      model_reset();
      @(posedge clock);
      #1;
      chk("reset_ignores_inputs", 64'(out_valid), 64'd0);
      reset = 0;
      idle_inputs();
      out_ready = 1;
      step();
      set_bk(0, 11, 2, 50'hA000, 0, 1);
      step();
      chk("post_reset_latency", 64'(out_valid), 64'd1);
      chk("post_reset_target", 64'(out_target), 64'hA000);
      idle_inputs();
      step();

      // Random traffic concentrated near the wrap point to exercise ordering.
      for (int n = 0; n < 600; n++) begin
         int f, i;
         idle_inputs();
         if ($urandom_range(0, 99) < 40) begin
            f = $urandom_range(0, 1);
            i = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(60, 63);
            set_bk(f, i, $urandom_range(0, 3), PC_W'({$urandom(), $urandom()}),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         if ($urandom_range(0, 99) < 40) begin
            f = $urandom_range(0, 1);
            i = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(60, 63);
            set_ifu(f, i, $urandom_range(0, 3), PC_W'({$urandom(), $urandom()}));
         end
         out_ready = 1'($urandom_range(0, 1));
         step();
      end

      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
